remap_cache_banked: RTL and testbench

Parametrised successor of the XOR-remapped vector cache in the TileAccumUnit read pipeline. It decouples lane count (VSIZE) from bank count (NBANK) and removes the conflict-free-access restriction. Lanes whose remapped addresses collide on a bank are serialised over extra issue rounds, and the output is delivered as one vector. Retiring reads free their config ID as before.

---
 rtl/remap_cache_banked.sv | 211 +++++++++++++++++++++
 tb/tb_remap_cache_banked.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/remap_cache_banked.sv
// remap_cache_banked: XOR-remapped banked vector read cache; lanes colliding on a bank are serialised.
// Optional conflict-round counter output o_conflict_rounds when REMAP_CACHE_BANKED_STAT_EN is defined.
module remap_cache_banked #(
    parameter  int LBW     = 8,
    parameter  int DBW     = 16,
    parameter  int VSIZE   = 4,
    parameter  int NBANK   = 4,
    parameter  int N_ICFG  = 4,
    localparam int BBW     = $clog2(NBANK),
    localparam int HBW     = LBW - BBW,
    localparam int ICFG_BW = $clog2(N_ICFG + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [BBW*N_ICFG-1:0]    i_xor_masks,
    input  logic                     i_ra_rdy,
    output logic                     o_ra_ack,
    input  logic [ICFG_BW-1:0]       i_rid,
    input  logic [LBW*VSIZE-1:0]     i_raddr,
    input  logic                     i_retire,
    output logic                     o_rd_rdy,
    input  logic                     i_rd_ack,
    output logic [DBW*VSIZE-1:0]     o_rdata,
    output logic                     o_free_dval,
    output logic [ICFG_BW-1:0]       o_free_id,
`ifdef REMAP_CACHE_BANKED_STAT_EN
    output logic [31:0]              o_conflict_rounds,
`endif
    input  logic                     i_wad_dval,
    input  logic [ICFG_BW-1:0]       i_wid,
    input  logic [HBW-1:0]           i_whiaddr,
    input  logic [DBW*NBANK-1:0]     i_wdata
);

    localparam int LW = (VSIZE > 1) ? $clog2(VSIZE) : 1;

    // state  | meaning
    // IDLE   | accept a read request
    // ISSUE  | one round per cycle: each bank serves its lowest pending lane
    // DRAIN  | capture the last round's SRAM outputs
    // OUT    | present o_rdata until i_rd_ack
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

    state_t               state_q, state_d;
    logic [LBW-1:0]       addr_q [VSIZE];
    logic [ICFG_BW-1:0]   id_q;
    logic                 retire_q;
    logic [BBW-1:0]       mask_q;
    logic [VSIZE-1:0]     pend_q, pend_d;
    logic [NBANK-1:0]     gvld_q;
    logic [LW-1:0]        glane_q [NBANK];
    logic [DBW-1:0]       rd_q [NBANK];
    logic [DBW-1:0]       rdata_q [VSIZE];
    logic                 free_dval_q;
    logic [ICFG_BW-1:0]   free_id_q;
    logic [DBW-1:0]       mem_q [NBANK][1<<HBW];

    logic [BBW-1:0]       lane_bank [VSIZE];
    logic [NBANK-1:0]     gnt_vld;
    logic [LW-1:0]        gnt_lane [NBANK];
    logic [HBW-1:0]       rd_idx [NBANK];
    logic [VSIZE-1:0]     lane_gnt;
    logic [BBW-1:0]       wbank [NBANK];
    logic [BBW-1:0]       wmask;
    logic                 accept;

    // Out-of-range config IDs behave as an all-zero mask.
    function automatic logic [BBW-1:0] mask_of(input logic [BBW*N_ICFG-1:0] masks,
                                                input logic [ICFG_BW-1:0]    id);
        logic [BBW-1:0] m;
        m = '0;
        if (int'(id) < N_ICFG)
            m = masks[int'(id)*BBW +: BBW];
        return m;
    endfunction

    assign accept = (state_q == S_IDLE) && i_ra_rdy && !i_rst;
    assign wmask  = mask_of(i_xor_masks, i_wid);

    always_comb begin
        for (int l = 0; l < VSIZE; l++)
            lane_bank[l] = addr_q[l][BBW-1:0] ^ (addr_q[l][BBW +: BBW] & mask_q);
        for (int b = 0; b < NBANK; b++)
            wbank[b] = BBW'(b) ^ (i_whiaddr[BBW-1:0] & wmask);
    end

    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            gnt_vld[b]  = 1'b0;
            gnt_lane[b] = '0;
            // Scanning downward leaves the lowest-indexed pending lane as winner.
            for (int l = VSIZE - 1; l >= 0; l--) begin
                if (pend_q[l] && (lane_bank[l] == BBW'(b))) begin
                    gnt_vld[b]  = 1'b1;
                    gnt_lane[b] = LW'(l);
                end
            end
            rd_idx[b] = addr_q[gnt_lane[b]][LBW-1:BBW];
        end
        for (int l = 0; l < VSIZE; l++)
            lane_gnt[l] = pend_q[l] && gnt_vld[lane_bank[l]]
                          && (gnt_lane[lane_bank[l]] == LW'(l));
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        o_ra_ack = 1'b0;
        o_rd_rdy = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_ra_ack = i_ra_rdy && !i_rst;
                if (i_ra_rdy) begin
                    state_d = S_ISSUE;
                    pend_d  = '1;
                end
            end
            S_ISSUE: begin
                pend_d = pend_q & ~lane_gnt;
                if (pend_d == '0)
                    state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_OUT;
            S_OUT: begin
                o_rd_rdy = 1'b1;
                if (i_rd_ack)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            gvld_q      <= '0;
            id_q        <= '0;
            retire_q    <= 1'b0;
            mask_q      <= '0;
            free_dval_q <= 1'b0;
            free_id_q   <= '0;
            for (int l = 0; l < VSIZE; l++) begin
                addr_q[l]  <= '0;
                rdata_q[l] <= '0;
            end
            for (int b = 0; b < NBANK; b++)
                glane_q[b] <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (accept) begin
                for (int l = 0; l < VSIZE; l++)
                    addr_q[l] <= i_raddr[l*LBW +: LBW];
                id_q     <= i_rid;
                retire_q <= i_retire;
                mask_q   <= mask_of(i_xor_masks, i_rid);
            end
            gvld_q <= (state_q == S_ISSUE) ? gnt_vld : '0;
            for (int b = 0; b < NBANK; b++) begin
                glane_q[b] <= gnt_lane[b];
                if (gvld_q[b])
                    rdata_q[glane_q[b]] <= rd_q[b];
            end
            free_dval_q <= (state_q == S_OUT) && i_rd_ack && retire_q;
            if ((state_q == S_OUT) && i_rd_ack && retire_q)
                free_id_q <= id_q;
        end
    end

    // SRAM array is never reset; a same-edge write leaves the read seeing old data.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < NBANK; b++)
            rd_q[b] <= mem_q[b][rd_idx[b]];
        if (i_wad_dval) begin
            for (int k = 0; k < NBANK; k++)
                mem_q[wbank[k]][i_whiaddr] <= i_wdata[k*DBW +: DBW];
        end
    end

`ifdef REMAP_CACHE_BANKED_STAT_EN
    logic [31:0] stat_q;
    logic        first_q;

    // Every round after the first of a request is one extra conflict round.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stat_q  <= '0;
            first_q <= 1'b0;
        end else begin
            if (accept)
                first_q <= 1'b1;
            else if (state_q == S_ISSUE)
                first_q <= 1'b0;
            if ((state_q == S_ISSUE) && !first_q && (stat_q != 32'hFFFF_FFFF))
                stat_q <= stat_q + 32'd1;
        end
    end

    assign o_conflict_rounds = stat_q;
`endif

    always_comb begin
        for (int l = 0; l < VSIZE; l++)
            o_rdata[l*DBW +: DBW] = rdata_q[l];
    end

    assign o_free_dval = free_dval_q;
    assign o_free_id   = free_id_q;

endmodule

// File: tb/tb_remap_cache_banked.sv
// Scoreboard bench for remap_cache_banked (VSIZE=NBANK=4); expected lane data from a bank/row model.
module tb_remap_cache_banked;

    localparam int LBW = 8, DBW = 16, VSIZE = 4, NBANK = 4, N_ICFG = 4;
    localparam int BBW = 2, HBW = 6, ICFG_BW = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [BBW*N_ICFG-1:0] xor_masks;
    logic                  ra_rdy, ra_ack;
    logic [ICFG_BW-1:0]    rid;
    logic [LBW*VSIZE-1:0]  raddr;
    logic                  retire;
    logic                  rd_rdy, rd_ack;
    logic [DBW*VSIZE-1:0]  rdata;
    logic                  free_dval;
    logic [ICFG_BW-1:0]    free_id;
    logic [31:0]           stat;
    logic                  wad_dval;
    logic [ICFG_BW-1:0]    wid;
    logic [HBW-1:0]        whi;
    logic [DBW*NBANK-1:0]  wdata;

    remap_cache_banked #(.LBW(LBW), .DBW(DBW), .VSIZE(VSIZE), .NBANK(NBANK), .N_ICFG(N_ICFG)) dut (
`ifdef REMAP_CACHE_BANKED_STAT_EN
        .o_conflict_rounds(stat),
`endif
        .i_clk(clk), .i_rst(rst), .i_xor_masks(xor_masks),
        .i_ra_rdy(ra_rdy), .o_ra_ack(ra_ack), .i_rid(rid), .i_raddr(raddr), .i_retire(retire),
        .o_rd_rdy(rd_rdy), .i_rd_ack(rd_ack), .o_rdata(rdata),
        .o_free_dval(free_dval), .o_free_id(free_id),
        .i_wad_dval(wad_dval), .i_wid(wid), .i_whiaddr(whi), .i_wdata(wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];
    logic [1:0]  msk [N_ICFG] = '{2'd0, 2'd3, 2'd1, 2'd2};
    logic [DBW-1:0] mdl [NBANK][64];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_lanes(input logic [2:0] id, input logic [31:0] a);
        logic [63:0] e;
        logic [7:0]  ad;
        logic [1:0]  b;
        e = '0;
        for (int l = 0; l < VSIZE; l++) begin
            ad = a[l*8 +: 8];
            b  = ad[1:0] ^ (ad[3:2] & msk[id]);
            e[l*16 +: 16] = mdl[b][ad[7:2]];
        end
        return e;
    endfunction

    function automatic int exp_k(input logic [2:0] id, input logic [31:0] a);
        int cnt [NBANK];
        int mx;
        logic [7:0] ad;
        logic [1:0] b;
        mx = 0;
        for (int i = 0; i < NBANK; i++) cnt[i] = 0;
        for (int l = 0; l < VSIZE; l++) begin
            ad = a[l*8 +: 8];
            b  = ad[1:0] ^ (ad[3:2] & msk[id]);
            cnt[b]++;
            if (cnt[b] > mx) mx = cnt[b];
        end
        return mx;
    endfunction

    task automatic model_write(input logic [2:0] id, input logic [5:0] row, input logic [63:0] d);
        for (int k = 0; k < NBANK; k++)
            mdl[2'(k) ^ (row[1:0] & msk[id])][row] = d[k*16 +: 16];
    endtask

    // Tasks start and end just after a falling edge.
    task automatic write_row(input logic [2:0] id, input logic [5:0] row, input logic [63:0] d);
        wad_dval = 1'b1; wid = id; whi = row; wdata = d;
        model_write(id, row, d);
        @(negedge clk);
        wad_dval = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [2:0] id, input logic [31:0] a,
                           input bit ret, input bit hold, input bit wr_issue, input logic [63:0] wr_d);
        int k, c_ack, w;
        logic [63:0] exp;
        logic [31:0] stat0;
        rid = id; raddr = a; retire = ret; ra_rdy = 1'b1;
        #1;
        w = 0;
        while (!ra_ack && w < 20) begin @(negedge clk); #1; w++; end
        if (!ra_ack) begin chk({tag, "_ack_timeout"}, 0, 1); ra_rdy = 1'b0; return; end
        c_ack = cyc;
        k = exp_k(id, a);
        sb_q.push_back(exp_lanes(id, a));
        stat0 = stat;
        @(negedge clk);
        ra_rdy = 1'b0;
        if (wr_issue) begin
            wad_dval = 1'b1; wid = id; whi = a[7:2]; wdata = wr_d;
            model_write(id, a[7:2], wr_d);
            @(negedge clk);
            wad_dval = 1'b0;
        end
        w = 0;
        while (!rd_rdy && w < 40) begin @(negedge clk); w++; end
        if (!rd_rdy) begin chk({tag, "_rdy_timeout"}, 0, 1); void'(sb_q.pop_front()); return; end
        exp = sb_q.pop_front();
        chk({tag, "_lat"}, 64'(cyc - c_ack), 64'(k + 2));
        chk({tag, "_data"}, rdata, exp);
`ifdef REMAP_CACHE_BANKED_STAT_EN
        chk({tag, "_stat"}, 64'(stat - stat0), 64'(k - 1));
`endif
        if (hold) begin
            ra_rdy = 1'b1;
            repeat (5) begin
                @(negedge clk); #1;
                chk({tag, "_hold_rdy"}, rd_rdy, 1);
                chk({tag, "_hold_data"}, rdata, exp);
                chk({tag, "_hold_noack"}, ra_ack, 0);
            end
            ra_rdy = 1'b0;
        end
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        chk({tag, "_free"}, free_dval, ret);
        if (ret) chk({tag, "_free_id"}, free_id, id);
        chk({tag, "_rdy_drop"}, rd_rdy, 0);
        @(negedge clk);
        chk({tag, "_free_pulse"}, free_dval, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  id;
        int seen;
        stat = '0;
        xor_masks = {msk[3], msk[2], msk[1], msk[0]};
        rst = 1'b1; ra_rdy = 1'b1; rid = '0; raddr = '0; retire = 1'b0; rd_ack = 1'b0;
        wad_dval = 1'b0; wid = '0; whi = '0; wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ra_ack", ra_ack, 0);
        chk("rst_rd_rdy", rd_rdy, 0);
        chk("rst_free", free_dval, 0);
        chk("rst_free_id", free_id, 0);
        chk("rst_rdata", rdata, 0);
`ifdef REMAP_CACHE_BANKED_STAT_EN
        chk("rst_stat", stat, 0);
`endif
        ra_rdy = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        write_row(3'd0, 6'd5, {16'd13, 16'd12, 16'd11, 16'd10});
        do_read("plain", 3'd0, {8'd23, 8'd22, 8'd21, 8'd20}, 1'b0, 1'b0, 1'b0, '0);
        write_row(3'd1, 6'd5, {16'd13, 16'd12, 16'd11, 16'd10});
        do_read("mask3", 3'd1, {8'd23, 8'd22, 8'd21, 8'd20}, 1'b0, 1'b0, 1'b0, '0);
        do_read("permute", 3'd0, {8'd23, 8'd22, 8'd21, 8'd20}, 1'b0, 1'b0, 1'b0, '0);

        for (int r = 0; r < 4; r++)
            write_row(3'd0, 6'(r), {16'(r*16+3), 16'(r*16+2), 16'(r*16+1), 16'(r*16)});
        do_read("conflict4", 3'd0, {8'd12, 8'd8, 8'd4, 8'd0}, 1'b0, 1'b0, 1'b0, '0);
        do_read("retire", 3'd2, {8'd3, 8'd6, 8'd9, 8'd12}, 1'b1, 1'b0, 1'b0, '0);
        do_read("hold", 3'd3, {8'd1, 8'd1, 8'd2, 8'd7}, 1'b0, 1'b1, 1'b0, '0);
        do_read("wr_issue", 3'd0, {8'd23, 8'd22, 8'd21, 8'd20}, 1'b0, 1'b0, 1'b1,
                {16'hAAA3, 16'hAAA2, 16'hAAA1, 16'hAAA0});
        do_read("after_wr", 3'd0, {8'd23, 8'd22, 8'd21, 8'd20}, 1'b0, 1'b0, 1'b0, '0);

        for (int r = 8; r < 12; r++)
            write_row(3'($urandom_range(0, 3)), 6'(r), {$urandom, $urandom});
        for (int n = 0; n < 8; n++) begin
            for (int l = 0; l < VSIZE; l++) a[l*8 +: 8] = 8'($urandom_range(32, 47));
            id = 3'($urandom_range(0, 3));
            do_read("rand", id, a, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0);
        end

        rid = 3'd1; raddr = {8'd12, 8'd8, 8'd4, 8'd0}; retire = 1'b1; ra_rdy = 1'b1;
        #1;
        seen = 0;
        while (!ra_ack && seen < 20) begin @(negedge clk); #1; seen++; end
        chk("mid_rst_ack", ra_ack, 1);
        @(negedge clk);
        ra_rdy = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_rdy", rd_rdy, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_free", free_dval, 0);
        chk("mid_rst_free_id", free_id, 0);
`ifdef REMAP_CACHE_BANKED_STAT_EN
        chk("mid_rst_stat", stat, 0);
`endif
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rd_rdy || free_dval) seen++;
        end
        chk("mid_rst_abandon", seen, 0);
        do_read("post_rst", 3'd0, {8'd12, 8'd8, 8'd4, 8'd0}, 1'b1, 1'b0, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
